// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions for the Memory->Writeback boundary: pipeline bundle,
// data-bus request/response types, opcode constants and handshake state enum.
package mem_wb_stage_pkg;

  localparam int WORD_BITS = 32;
  localparam int REG_BITS  = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;

  typedef struct packed {
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic [WORD_BITS-1:0] valE;
    logic [REG_BITS-1:0]  dstE;
    logic [REG_BITS-1:0]  dstM;
    logic [WORD_BITS-1:0] pc;
  } plr_w;

  typedef struct packed {
    logic                 valid;
    logic [WORD_BITS-1:0] addr;
    logic [1:0]           size;
    logic [3:0]           strobe;
    logic [WORD_BITS-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                 addr_ok;
    logic                 data_ok;
    logic [WORD_BITS-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } mwb_state_t;

  // A request with no byte strobes is a read.
  function automatic logic is_load(input dbus_req_t req);
    return (req.strobe == 4'h0);
  endfunction

endpackage

// File: rtl/mem_wb_stage_dbus_fsm.sv
// Data-bus handshake sequencer: presents the Memory-stage request, tracks the
// outstanding access and produces the stall and access-complete signals.
module dbus_handshake_fsm
  import mem_wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_m_valid,
  input  dbus_req_t  i_m_req,
  input  dbus_resp_t i_dresp,
  output dbus_req_t  o_dreq,
  output logic       o_stall,
  output logic       o_complete
);

  mwb_state_t r_state;
  mwb_state_t w_next;
  dbus_req_t  w_dreq;
  logic       w_active;
  logic       w_complete;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state, bus request gating and completion detect
  always_comb begin
    w_next       = r_state;
    w_dreq       = i_m_req;
    w_dreq.valid = 1'b0;
    w_active     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE, WAIT_ADDR: begin
        if ((r_state == WAIT_ADDR) || (i_m_valid && i_m_req.valid)) begin
          w_dreq.valid = 1'b1;
          w_active     = 1'b1;
          if (i_dresp.addr_ok && i_dresp.data_ok) begin
            w_complete = 1'b1;
            w_next     = IDLE;
          end else if (i_dresp.addr_ok) begin
            w_next = WAIT_DATA;
          end else begin
            w_next = WAIT_ADDR;
          end
        end else begin
          w_next = IDLE;
        end
      end
      WAIT_DATA: begin
        w_active = 1'b1;
        if (i_dresp.data_ok) begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end else begin
          w_next = WAIT_DATA;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Nothing is issued or completed while reset is held.
    if (reset) begin
      w_dreq.valid = 1'b0;
      w_active     = 1'b0;
      w_complete   = 1'b0;
    end else begin
      w_dreq.valid = w_dreq.valid;
    end
  end

  assign o_dreq     = w_dreq;
  assign o_complete = w_complete;
  assign o_stall    = w_active & ~w_complete;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory->Writeback stage: drives the data-bus handshake, holds the W pipeline
// register plus captured load data, and generates register-file writes.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int WORD_W = WORD_BITS,
  parameter int REG_W  = REG_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  plr_w              m_bundle,
  input  dbus_req_t         m_req,
  input  logic              m_alu_ok,
  output dbus_req_t         dreq,
  input  dbus_resp_t        dresp,
  output logic              stall_m,
  output logic              w_valid,
  output plr_w              w_bundle,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [WORD_W-1:0] rf_wdata
);

  logic              w_complete;
  logic              r_w_valid;
  plr_w              r_w_bundle;
  logic [WORD_W-1:0] r_load_data;
  logic              r_alu_ok;

  dbus_handshake_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .i_m_valid  (m_valid),
    .i_m_req    (m_req),
    .i_dresp    (dresp),
    .o_dreq     (dreq),
    .o_stall    (stall_m),
    .o_complete (w_complete)
  );

  // W pipeline register: bubble while stalled, otherwise advance from M
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_valid   <= 1'b0;
      r_w_bundle  <= '0;
      r_load_data <= '0;
      r_alu_ok    <= 1'b0;
    end else if (!stall_m) begin
      r_w_valid  <= m_valid;
      r_w_bundle <= m_bundle;
      r_alu_ok   <= m_alu_ok;
      if (w_complete && is_load(m_req)) begin
        r_load_data <= dresp.data;
      end else begin
        r_load_data <= r_load_data;
      end
    end else begin
      r_w_valid <= 1'b0;
    end
  end

  // writeback select; r0 is never written
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (r_w_bundle.opcode == OP_LW) begin
      rf_we    = r_w_valid;
      rf_waddr = r_w_bundle.dstM;
      rf_wdata = r_load_data;
    end else if (r_alu_ok) begin
      rf_we    = r_w_valid;
      rf_waddr = r_w_bundle.dstE;
      rf_wdata = r_w_bundle.valE;
    end else begin
      rf_we = 1'b0;
    end
    if (rf_waddr == '0) begin
      rf_we = 1'b0;
    end else begin
      rf_we = rf_we;
    end
  end

  assign w_valid  = r_w_valid;
  assign w_bundle = r_w_bundle;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Sits between the Memory stage and the register file; owns the data-bus handshake for loads and stores.
- The Memory stage produces a bus request and a writeback bundle combinationally. This block:
  - sequences the request on the bus;
  - stalls the M stage while an access is outstanding;
  - registers the bundle and load data into the W pipeline register;
  - drives register-file writes from that register.

Parameters:
- WORD_W, 32, datapath and bus data width.
- REG_W, 5, register-file address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  1  M stage holds a live instruction.
- m_bundle  in  plr_w  writeback bundle from Memory (opcode, funct, valE, dstE, dstM, pc).
- m_req  in  dbus_req_t  data request from Memory (valid, addr, size, strobe, data).
- m_alu_ok  in  1  instruction writes valE to dstE (the Memory stage's MvEok).
- dreq  out  dbus_req_t  request to data bus.
- dresp  in  dbus_resp_t  bus response (addr_ok, data_ok, data).
- stall_m  out  1  hold M (and upstream) registers this cycle.
- w_valid  out  1  W register holds a live instruction.
- w_bundle  out  plr_w  registered bundle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_W  write address.
- rf_wdata  out  WORD_W  write data.

Behaviour:
- Reset:
  - state=IDLE.
  - w_valid=0, w_bundle='0, load-data reg=0, alu_ok reg=0.
  - dreq.valid=0, stall_m=0, rf_we=0.
  - The bus shares this reset, so no response from before reset is ever delivered after it.
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA.
  - IDLE, m_valid&m_req.valid: dreq=m_req (valid=1).
    - addr_ok&data_ok -> stay IDLE, access complete.
    - addr_ok only -> WAIT_DATA.
    - neither -> WAIT_ADDR.
  - WAIT_ADDR: dreq=m_req, valid=1; m_req must be held stable by the stall.
    - addr_ok&data_ok -> IDLE, complete.
    - addr_ok -> WAIT_DATA.
    - else stay.
  - WAIT_DATA: dreq.valid=0.
    - data_ok -> IDLE, complete.
    - else stay.
  - data_ok while dreq.valid=0 in IDLE is ignored.
- Stall: stall_m=1 whenever an access is begun or outstanding and data_ok is not asserted this cycle. It is combinational from state, m_req.valid and dresp.
- W register update, every edge:
  - stall_m=1: w_valid<=0 (bubble); w_bundle is don't-care but held.
  - stall_m=0:
    - w_valid<=m_valid, w_bundle<=m_bundle, alu_ok reg<=m_alu_ok.
    - If the access completed this cycle and is a load (strobe==0), load-data reg<=dresp.data.
- Writeback, combinational from W register:
  - LW: rf_we=w_valid, rf_waddr=dstM, rf_wdata=load-data reg.
  - alu_ok reg=1: rf_we=w_valid, rf_waddr=dstE, rf_wdata=valE. JAL's link value is already in valE.
  - Address 0: rf_we forced 0 for either case.
  - Stores, branches and others: rf_we=0.
- Latency:
  - Non-memory instruction: 1 cycle M->W.
  - Memory instruction: 1 + cycles until data_ok. Zero extra cycles when addr_ok&data_ok arrive in the first cycle.
- Back-to-back accesses: a new request may be issued in the cycle after completion. There is never more than one request outstanding.
- Stores: complete on data_ok; no data captured.
- Reset mid-access: FSM returns to IDLE and W is cleared; the in-flight instruction is dropped.

Decomposition:
- Shared package (mycpu defs):
  - plr_w, dbus_req_t, dbus_resp_t, opcode constants (OP_LW, OP_SW, ...), MSIZE4.
  - New enum mwb_state_t {IDLE, WAIT_ADDR, WAIT_DATA}.
- One natural sub-module: dbus_handshake_fsm (state, dreq gating, stall, complete pulse). The W register and writeback mux stay in the top.

Test Plan:
- ALU op: m_valid=1, ADDIU, m_alu_ok=1, valE=0x1234, dstE=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; stall_m never 1.
- Zero-wait LW: addr=0x80, dstM=7; addr_ok=data_ok=1, data=0xDEADBEEF in the same cycle -> stall_m=0; next cycle rf_we=1, waddr=7, wdata=0xDEADBEEF.
- Slow LW: addr_ok after 2 cycles, data_ok 3 cycles later -> dreq.valid high exactly 3 cycles; stall_m=1 for 5 cycles; w_valid=0 during the stall; a single write with the data from the data_ok cycle.
- SW with delay: strobe=0xF, data=0xA5A5A5A5, addr_ok+data_ok after 1 cycle -> dreq.data=0xA5A5A5A5; stall 1 cycle; rf_we never 1.
- Writes to r0: ADDIU with dstE=0, and LW with dstM=0 -> rf_we=0 both.
- Reset during WAIT_DATA -> next cycle state IDLE, w_valid=0, stall_m=0, dreq.valid=0.
